// File: rtl/qacc_requant_pkg.sv
// Shared types and helpers for the accumulate/requantise stage: FSM state encoding
// and activation range limits.
package qacc_requant_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_BIAS,
    S_REQ,
    S_OUT
  } state_t;

  localparam int N_DEF   = 8;
  localparam int ACT_MAX = (1 << (N_DEF - 1)) - 1;
  localparam int ACT_MIN = -(1 << (N_DEF - 1));

  function automatic longint act_max(int n);
    return (longint'(1) << (n - 1)) - 1;
  endfunction

  function automatic longint act_min(int n);
    return -(longint'(1) << (n - 1));
  endfunction

endpackage

// File: rtl/qacc_requant_if.sv
// Neuron control, product stream and activation result bundle between the
// multiplier side (master) and the accumulate/requantise stage (slave).
interface qacc_requant_if #(
  parameter int N       = 8,
  parameter int LEN_MAX = 16,
  parameter int SH_W    = 5
);
  localparam int LW = $clog2(LEN_MAX + 1);

  logic                  start;
  logic [LW-1:0]         len_din;
  logic signed [2*N-1:0] bias_din;
  logic [SH_W-1:0]       shift_din;
  logic                  relu_en;
  logic signed [2*N-1:0] product_din;
  logic                  product_vld;
  logic                  busy;
  logic signed [N-1:0]   act_dout;
  logic                  act_dout_vld;
  logic                  sat_flag;
  logic                  stray;

  modport master (
    output start, len_din, bias_din, shift_din, relu_en, product_din, product_vld,
    input  busy, act_dout, act_dout_vld, sat_flag, stray
  );

  modport slave (
    input  start, len_din, bias_din, shift_din, relu_en, product_din, product_vld,
    output busy, act_dout, act_dout_vld, sat_flag, stray
  );

endinterface

// File: rtl/qacc_requant_qround_sat.sv
// Combinational requantiser: round-half-up arithmetic right shift, optional ReLU,
// then saturation of the wide accumulator to a signed N-bit activation.
module qround_sat
  import qacc_requant_pkg::*;
#(
  parameter int N     = 8,
  parameter int ACC_W = 32,
  parameter int SH_W  = 5
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic [SH_W-1:0]         shift,
  input  logic                    relu_en,
  output logic signed [N-1:0]     act,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(act_max(N));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(act_min(N));

  logic signed [ACC_W-1:0] half;
  logic signed [ACC_W-1:0] r;

  always_comb begin
    half = '0;
    if (shift != '0) begin
      half = ACC_W'(1) << (shift - 1'b1);
    end
    r = (acc + half) >>> shift;
    // ReLU runs before the clip so a clamped negative never counts as saturation
    if (relu_en && (r < 0)) begin
      r = '0;
    end
    sat = 1'b0;
    act = r[N-1:0];
    if (r > HI) begin
      act = HI[N-1:0];
      sat = 1'b1;
    end else if (r < LO) begin
      act = LO[N-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/qacc_requant.sv
// Per-neuron accumulator: sums LEN signed products, adds bias, requantises to an
// N-bit activation and pulses it out once per accepted start.
module qacc_requant
  import qacc_requant_pkg::*;
#(
  parameter int N       = 8,
  parameter int LEN_MAX = 16,
  parameter int ACC_W   = 32,
  parameter int SH_W    = 5
) (
  input  logic          clk,
  input  logic          rst,
  qacc_requant_if.slave bus
);

  localparam int LW = $clog2(LEN_MAX + 1);

  if (ACC_W < 2*N + LW + 1) begin : g_acc_w_check
    $error("qacc_requant: ACC_W too small for N and LEN_MAX");
  end

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [LW-1:0]           cnt_reg, cnt_next;
  logic [LW-1:0]           len_reg, len_next;
  logic signed [2*N-1:0]   bias_reg, bias_next;
  logic [SH_W-1:0]         shift_reg, shift_next;
  logic                    relu_reg, relu_next;
  logic signed [N-1:0]     act_reg, act_next;
  logic                    sat_reg, sat_next;
  logic                    stray_reg, stray_next;

  logic signed [N-1:0]     rs_act;
  logic                    rs_sat;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] bias_ext;

  assign product_ext = {{(ACC_W-2*N){bus.product_din[2*N-1]}}, bus.product_din};
  assign bias_ext    = {{(ACC_W-2*N){bias_reg[2*N-1]}}, bias_reg};

  qround_sat #(
    .N     (N),
    .ACC_W (ACC_W),
    .SH_W  (SH_W)
  ) u_qround_sat (
    .acc     (acc_reg),
    .shift   (shift_reg),
    .relu_en (relu_reg),
    .act     (rs_act),
    .sat     (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      len_reg   <= '0;
      bias_reg  <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
      act_reg   <= '0;
      sat_reg   <= 1'b0;
      stray_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      bias_reg  <= bias_next;
      shift_reg <= shift_next;
      relu_reg  <= relu_next;
      act_reg   <= act_next;
      sat_reg   <= sat_next;
      stray_reg <= stray_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    bias_next  = bias_reg;
    shift_next = shift_reg;
    relu_next  = relu_reg;
    act_next   = act_reg;
    sat_next   = sat_reg;
    stray_next = stray_reg;

    // A product outside ACC is dropped; the start cycle itself is exempt
    if (bus.product_vld && (state_reg != S_ACC) &&
        !((state_reg == S_IDLE) && bus.start)) begin
      stray_next = 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          len_next   = bus.len_din;
          bias_next  = bus.bias_din;
          shift_next = bus.shift_din;
          relu_next  = bus.relu_en;
          acc_next   = '0;
          cnt_next   = '0;
          stray_next = 1'b0;
          state_next = (bus.len_din == '0) ? S_BIAS : S_ACC;
        end
      end
      S_ACC: begin
        if (bus.product_vld) begin
          acc_next = acc_reg + product_ext;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == len_reg - 1'b1) begin
            state_next = S_BIAS;
          end
        end
      end
      S_BIAS: begin
        acc_next   = acc_reg + bias_ext;
        state_next = S_REQ;
      end
      S_REQ: begin
        act_next   = rs_act;
        sat_next   = rs_sat;
        state_next = S_OUT;
      end
      S_OUT: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.busy         = (state_reg != S_IDLE);
  assign bus.act_dout_vld = (state_reg == S_OUT);
  assign bus.act_dout     = act_reg;
  assign bus.sat_flag     = sat_reg;
  assign bus.stray        = stray_reg;

endmodule

// File: tb/tb_qacc_requant.sv
// Directed bench for qacc_requant: a scoreboard of model-computed results checked
// on every output pulse, plus hand-computed literal checks per neuron.
module tb_qacc_requant;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qacc_requant_if #(.N(8), .LEN_MAX(16), .SH_W(5)) bus ();

  qacc_requant #(
    .N       (8),
    .LEN_MAX (16),
    .ACC_W   (32),
    .SH_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int act;
    bit sat;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   prod_q[$];

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // Reference requantiser using floor division rather than shifts
  function automatic void model(input longint sum, input int sh, input bit relu,
                                output int act, output bit sat);
    longint r, d, num;
    if (sh == 0) begin
      r = sum;
    end else begin
      d = 1;
      for (int i = 0; i < sh; i++) d = d * 2;
      num = sum + d / 2;
      r = num / d;
      if ((num % d) != 0 && num < 0) r = r - 1;
    end
    if (relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 127) begin
      r = 127;
      sat = 1'b1;
    end else if (r < -128) begin
      r = -128;
      sat = 1'b1;
    end
    act = int'(r);
  endfunction

  // Compare process: every output pulse must match the next scoreboard entry at its cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        chk("missing_pulse_cycle", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (bus.act_dout_vld) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_act", bus.act_dout, e.act);
          chk("pulse_sat", bus.sat_flag, e.sat);
        end
      end
    end
  end

  task automatic push_exp(input longint sum, input int sh, input bit relu, input int when);
    exp_t e;
    model(sum, sh, relu, e.act, e.sat);
    e.cyc = when;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk({nm, "_idle_timeout"}, bus.busy, 0);
  endtask

  task automatic run_neuron(input string nm, input int len, input int bias, input int sh,
                            input bit relu, input int gap, input bit vld_at_start,
                            input int lit_act, input bit lit_sat);
    longint sum;
    sum = bias;
    foreach (prod_q[i]) sum += prod_q[i];
    bus.start       = 1'b1;
    bus.len_din     = 5'(len);
    bus.bias_din    = 16'(bias);
    bus.shift_din   = 5'(sh);
    bus.relu_en     = relu;
    bus.product_din = 16'sd999;
    bus.product_vld = vld_at_start;
    if (len == 0) push_exp(sum, sh, relu, cyc + 3);
    @(posedge clk) #1;
    bus.start       = 1'b0;
    bus.product_vld = 1'b0;
    @(negedge clk);
    chk({nm, "_stray_after_start"}, bus.stray, 0);
    chk({nm, "_busy_after_start"}, bus.busy, 1);
    @(posedge clk) #1;
    foreach (prod_q[i]) begin
      bus.product_din = 16'(prod_q[i]);
      bus.product_vld = 1'b1;
      if (i == prod_q.size() - 1) push_exp(sum, sh, relu, cyc + 3);
      @(posedge clk) #1;
      bus.product_vld = 1'b0;
      repeat (gap) @(posedge clk) #1;
    end
    wait_idle(nm);
    chk({nm, "_act_literal"}, bus.act_dout, lit_act);
    chk({nm, "_sat_literal"}, bus.sat_flag, lit_sat);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len_din = '0;
    bus.bias_din = '0;
    bus.shift_din = '0;
    bus.relu_en = 1'b0;
    bus.product_din = '0;
    bus.product_vld = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_act", bus.act_dout, 0);
    chk("reset_vld", bus.act_dout_vld, 0);
    chk("reset_sat", bus.sat_flag, 0);
    chk("reset_stray", bus.stray, 0);
    rst = 1'b0;
    @(posedge clk) #1;

    prod_q = '{100, -50, 20};
    run_neuron("t1_basic", 3, 30, 2, 0, 1, 0, 25, 0);
    chk("t1_stray_clear", bus.stray, 0);
    prod_q = '{16384, 16384};
    run_neuron("t2_sat_pos", 2, 0, 4, 0, 0, 0, 127, 1);
    prod_q = '{-16384, -16384};
    run_neuron("t2_sat_neg", 2, 0, 4, 0, 0, 0, -128, 1);
    prod_q = '{-1000};
    run_neuron("t3_norelu", 1, 0, 3, 0, 0, 0, -125, 0);
    run_neuron("t3_relu", 1, 0, 3, 1, 0, 0, 0, 0);
    prod_q = '{6};
    run_neuron("t4_round_pos", 1, 0, 2, 0, 0, 0, 2, 0);
    prod_q = '{-6};
    run_neuron("t4_round_neg", 1, 0, 2, 0, 0, 0, -1, 0);
    prod_q = '{5};
    run_neuron("t4_shift0", 1, 0, 0, 0, 0, 0, 5, 0);

    // len=0 with a second start raised while busy; it must not produce a result
    prod_q.delete();
    bus.start = 1'b1;
    bus.len_din = '0;
    bus.bias_din = 16'sd40;
    bus.shift_din = 5'd1;
    bus.relu_en = 1'b0;
    push_exp(40, 1, 0, cyc + 3);
    @(posedge clk) #1;
    bus.bias_din = 16'sd1000;
    bus.shift_din = 5'd0;
    @(negedge clk);
    chk("t5_busy_during_restart", bus.busy, 1);
    @(posedge clk) #1;
    bus.start = 1'b0;
    wait_idle("t5_len0");
    chk("t5_act_literal", bus.act_dout, 20);
    repeat (6) @(posedge clk);
    #1;

    // stray product in IDLE, then a neuron with a product in its start cycle
    bus.product_din = 16'sd77;
    bus.product_vld = 1'b1;
    @(posedge clk) #1;
    bus.product_vld = 1'b0;
    @(negedge clk);
    chk("t6_stray_set", bus.stray, 1);
    prod_q = '{50};
    run_neuron("t6_after_stray", 1, 0, 0, 0, 0, 1, 50, 0);

    // reset mid-accumulation
    prod_q.delete();
    bus.start = 1'b1;
    bus.len_din = 5'd4;
    bus.bias_din = '0;
    bus.shift_din = '0;
    @(posedge clk) #1;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.product_din = 16'sd300;
      bus.product_vld = 1'b1;
      @(posedge clk) #1;
    end
    bus.product_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_act", bus.act_dout, 0);
    chk("t6_rst_vld", bus.act_dout_vld, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t6_rst_no_late_pulse", bus.act_dout_vld, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
